// File: rtl/wallace_pkg.sv
// wallace_pkg: shared widths, FSM encodings and the carry-save Wallace multiplier used by wallace_dot_acc
package wallace_pkg;
  localparam int MUL_W = 32;
  localparam int PROD_W = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  // Reduces the 32 partial products with layers of 3:2 compressors (32 rows need 8 layers to reach 2), then one final add
  function automatic logic [PROD_W-1:0] wallace_mul(input logic [MUL_W-1:0] a, input logic [MUL_W-1:0] b);
    logic [PROD_W-1:0] r [MUL_W];
    logic [PROD_W-1:0] t [MUL_W];
    int n;
    int m;
    for (int i = 0; i < MUL_W; i++) r[i] = b[i] ? ({{(PROD_W-MUL_W){1'b0}}, a} << i) : '0;
    n = MUL_W;
    for (int l = 0; l < 8; l++) begin
      m = 0;
      for (int i = 0; i < MUL_W; i++) t[i] = '0;
      for (int g = 0; g < MUL_W / 3; g++)
        if (3 * g + 2 < n) begin
          t[m] = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
          t[m+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
          m += 2;
        end
      for (int i = 0; i < MUL_W; i++)
        if (i >= 3 * (n / 3) && i < n) begin
          t[m] = r[i];
          m++;
        end
      r = t;
      n = m;
    end
    return r[0] + r[1];
  endfunction
endpackage

// File: rtl/wallace_pipe_reg.sv
// wallace_pipe_reg: S1 operand register, combinational Wallace multiplier, S2 product register with valid/last sideband
module wallace_pipe_reg
  import wallace_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [MUL_W-1:0]  a_i,
  input  logic [MUL_W-1:0]  b_i,
  input  logic              last_i,
  output logic              v_o,
  output logic              last_o,
  output logic [PROD_W-1:0] prod_o
);
  logic [MUL_W-1:0] a_q, b_q;
  logic l1_q, v1_q, l2_q, v2_q;
  logic [PROD_W-1:0] p_q;
  // S1 captures operands only on a transfer so idle inputs never reach the tree
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      l1_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= v_i;
      if (v_i) begin
        a_q <= a_i;
        b_q <= b_i;
        l1_q <= last_i;
      end
    end
  // S2 registers the product one edge after the operands land
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_q <= '0;
      l2_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      l2_q <= v1_q & l1_q;
      if (v1_q) p_q <= wallace_mul(a_q, b_q);
    end
  assign v_o = v2_q;
  assign last_o = l2_q;
  assign prod_o = p_q;
endmodule

// File: rtl/wallace_dot_acc.sv
// wallace_dot_acc: streaming dot-product accumulator over wallace_pipe_reg; WALLACE_DOT_SAT_EN makes overflow clamp to all-ones
module wallace_dot_acc
  import wallace_pkg::*;
#(
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] in_a,
  input  logic [MUL_W-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  logic [1:0] st_q, st_d;
  logic fire, v2, l2, fin, take;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0] add;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_o_q;
  logic ovf_q, ovf_d, ovf_o_q;
  wallace_pipe_reg u_pipe (
    .clk(clk), .rst(rst), .v_i(fire), .a_i(in_a), .b_i(in_b), .last_i(in_last),
    .v_o(v2), .last_o(l2), .prod_o(prod)
  );
  assign fire = in_valid & in_ready;
  assign fin = (st_q == ST_DRAIN) & v2 & l2;
  assign take = (st_q == ST_DONE) & out_ready;
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= ST_IDLE;
    else st_q <= st_d;
  // Next state: any last-tagged transfer drains, even straight from IDLE
  always_comb
    st_d = ((st_q == ST_IDLE || st_q == ST_ACCUM) && fire) ? (in_last ? ST_DRAIN : ST_ACCUM) :
           fin ? ST_DONE :
           take ? ST_IDLE : st_q;
  // Handshake outputs; in_ready is masked by rst so it reads 0 throughout reset
  always_comb begin
    in_ready = ~rst & (st_q == ST_IDLE || st_q == ST_ACCUM);
    out_valid = st_q == ST_DONE;
  end
  // Accumulate the zero-extended product; the extra top bit of add is the carry that flags overflow
  always_comb begin
    add = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
`ifdef WALLACE_DOT_SAT_EN
    acc_d = v2 ? ((add[ACC_W] | ovf_q) ? '1 : add[ACC_W-1:0]) : acc_q;
`else
    acc_d = v2 ? add[ACC_W-1:0] : acc_q;
`endif
    cnt_d = (v2 && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = ovf_q | (v2 & add[ACC_W]);
  end
  // Working accumulator, cleared once the result is consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= take ? '0 : acc_d;
      cnt_q <= take ? '0 : cnt_d;
      ovf_q <= take ? 1'b0 : ovf_d;
    end
  // Result registers take the total including the final product as it accumulates
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sum_q <= '0;
      cnt_o_q <= '0;
      ovf_o_q <= 1'b0;
    end else if (fin) begin
      sum_q <= acc_d;
      cnt_o_q <= cnt_d;
      ovf_o_q <= ovf_d;
    end
  assign out_sum = sum_q;
  assign out_count = cnt_o_q;
  assign out_ovf = ovf_o_q;
endmodule
